ahb_sram_subordinate: RTL and testbench
=======================================

Name: ahb_sram_subordinate

Overview:
AHB-Lite subordinate (slave) SRAM model. It is the responding end of the manager/interconnect signal set that the cocotbext-ahb driver produces.
- Accepts pipelined address phases and serves single and burst transfers from an internal word array.
- Inserts a configurable number of wait states.
- Returns the two-cycle ERROR response for illegal accesses.
- Used as the reference subordinate for the cocotb AHB manager tests.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, hwdata/hrdata width; 32 or 64
MEM_DEPTH, 256, number of DATA_WIDTH words; word index = haddr >> log2(DATA_WIDTH/8)
WAIT_STATES, 0, hready-low cycles inserted before each OKAY read/write data phase; 0..15

Ports:
hclk  in  1  clock, rising edge
hresetn  in  1  reset, asynchronous assert, active-low
hsel  in  1  subordinate select
haddr  in  ADDR_WIDTH  byte address
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hsize  in  3  transfer size, bytes = 2**hsize
hburst  in  3  burst type; informational only, not checked
hprot  in  7  ignored
hwrite  in  1  1=write
hwdata  in  DATA_WIDTH  write data, valid in data phase
hready_in  in  1  bus ready (previous transfer complete)
hrdata  out  DATA_WIDTH  read data
hready  out  1  transfer-done / wait control
hresp  out  1  0=OKAY, 1=ERROR

Behaviour:
Reset state, forced asynchronously on hresetn low:
- hready=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0.
- Memory contents are not reset.

Address-phase acceptance:
- A transfer is accepted at a rising edge where hsel & hready_in & htrans[1] are all 1.
- On acceptance, latch haddr, hsize and hwrite.
- hsel=0, htrans=IDLE or BUSY, or hready_in=0: no transfer. The next cycle is a zero-wait OKAY (hready=1, hresp=0), with no memory access.

Error check, evaluated at acceptance. Any one of the following makes the transfer an error:
- word index >= MEM_DEPTH;
- hsize > log2(DATA_WIDTH/8);
- haddr not aligned to 2**hsize.

FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: accept OKAY transfer with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES; OKAY with WAIT_STATES=0 -> DATA; error -> ERR1; else stay.
- WAIT: hready=0, hresp=0, counter decrements each cycle; counter reaches 1 -> DATA.
- DATA: hready=1, hresp=0. Transfer completes at this edge. Next state is chosen from the current address phase, with the same rules as IDLE, so back-to-back transfers are supported.
- ERR1: hready=0, hresp=1; always -> ERR2. Wait states are never applied to errors.
- ERR2: hready=1, hresp=1. Next state is chosen from the current address phase, as in DATA. Per AHB the manager is expected to drive IDLE here, but the subordinate accepts whatever is presented.

Write:
- hwdata is sampled on the DATA edge only.
- Bytes are written little-endian: lane = haddr[log2(DATA_WIDTH/8)-1:0], lane count = 2**hsize. Other lanes are unchanged.
- ERROR transfers never modify memory.

Read:
- hrdata carries the full word at the latched index while state=DATA and hwrite=0; otherwise hrdata=0.
- Read-after-write: the read data phase must return bytes written by a write whose DATA edge occurred in the previous cycle, so forwarding or a combinational read is required.

Reset mid-transfer:
- An in-progress wait or error sequence is aborted, outputs return to their reset values, and no write is performed.

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF to 0x10 (hsize=2), then read 0x10 in the next address phase -> write completes with hready=1 and no stall; read DATA cycle hrdata=0xDEADBEEF, hresp=0.
2. Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23 (hsize=0), then word read of 0x20 -> hrdata=0x44332211. Then halfword write 0xAAAA to 0x22 -> word read of 0x20 = 0xAAAA2211.
3. WAIT_STATES=3, INCR4 read burst from 0x40 (NONSEQ then 3 SEQ), with SEQ held while hready=0 -> each beat shows hready low for exactly 3 cycles then high for 1; total 16 cycles; data correct per beat.
4. Read of word index MEM_DEPTH (0x400 at default), misaligned word read of 0x02, and hsize=3 on a 32-bit bus -> each gives hready=0/hresp=1 then hready=1/hresp=1, with no wait states. A write to 0x400 leaves memory unchanged.
5. BUSY inserted mid INCR burst, IDLE with hsel=1, and NONSEQ with hready_in=0 -> zero-wait OKAY; no memory change; burst resumes correctly after BUSY.
6. Deassert hresetn during the 2nd wait cycle of a write with WAIT_STATES=2 -> hready=1, hresp=0, hrdata=0 immediately; the target word is unchanged on a later read.

Source files
------------

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by an internal word array, with optional wait states and two-cycle ERROR responses.
// Latency: WAIT_STATES hready-low cycles before each OKAY data phase (0 = zero-wait); errors always take exactly 2 cycles.
// Backpressure: hready is driven low during wait and first error cycles; new address phases are taken only while ready.
//
// Ports:
//   hclk, hresetn        clock (rising edge), asynchronous active-low reset
//   hsel, haddr, htrans  address phase: select, byte address, transfer type
//   hsize, hwrite        address phase: transfer size (2**hsize bytes), direction
//   hburst, hprot        informational, ignored
//   hwdata               write data, sampled on the completing data-phase edge
//   hready_in            bus ready (previous transfer complete)
//   hrdata, hready, hresp  read data, transfer done, ERROR flag

module ahb_sram_subordinate #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [6:0]            hprot,
   input  logic                  hwrite,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready_in,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  hready,
   output logic                  hresp
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

   // Elaboration-time guard on the supported parameter space.
   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("ahb_sram_subordinate: DATA_WIDTH must be 32 or 64");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
      $error("ahb_sram_subordinate: WAIT_STATES must be 0..15");
   end

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q,   cnt_d;
   logic [IW-1:0]   idx_q,   idx_d;
   logic [LB-1:0]   lane_q,  lane_d;
   logic [2:0]      size_q,  size_d;
   logic            write_q, write_d;
   logic            hready_q, hready_d;
   logic            hresp_q,  hresp_d;

   // Word storage; deliberately not reset.
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic                  accept;
   logic                  addr_err;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [ADDR_WIDTH-1:0] align_mask;
   logic                  mem_we;
   logic [NB-1:0]         wr_be;

   // ------------------------------------------------------------------
   // Address-phase decode
   // ------------------------------------------------------------------
   always_comb begin
      accept     = hsel & hready_in & htrans[1];
      word_idx   = haddr >> LB;
      align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
      // Out of range, wider than the bus, or not naturally aligned.
      addr_err   = (word_idx >= ADDR_WIDTH'(MEM_DEPTH)) ||
                   (hsize > 3'(LB)) ||
                   ((haddr & align_mask) != '0);
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      size_d  = size_q;
      write_d = write_q;

      case (state_q)
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            // IDLE, DATA and ERR2 all end with hready high, so the address
            // phase on the bus right now is the one that decides what follows.
            state_d = ST_IDLE;
            if (accept) begin
               idx_d   = haddr[LB +: IW];
               lane_d  = haddr[LB-1:0];
               size_d  = hsize;
               write_d = hwrite;
               if (addr_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES != 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
      endcase

      // Outputs are registered from the state being entered.
      hready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
      hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         lane_q   <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         hready_q <= 1'b1;
         hresp_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         lane_q   <= lane_d;
         size_q   <= size_d;
         write_q  <= write_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
      end
   end

   // ------------------------------------------------------------------
   // Write path: byte lanes lane_q .. lane_q + 2**size_q - 1
   // ------------------------------------------------------------------
   always_comb begin
      wr_be = '0;
      for (int b = 0; b < NB; b++) begin
         if ((b >= int'(lane_q)) && (b < (int'(lane_q) + (1 << size_q)))) begin
            wr_be[b] = 1'b1;
         end
      end
   end

   // Only a DATA state can write; reset forces IDLE, so an aborted
   // transfer never reaches memory.
   assign mem_we = (state_q == ST_DATA) && write_q;

   always_ff @(posedge hclk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
               mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read path: combinational array read, so a write completing on the
   // previous edge is already visible in the next read data phase.
   // ------------------------------------------------------------------
   assign hrdata = ((state_q == ST_DATA) && !write_q) ? mem_q[idx_q] : '0;
   assign hready = hready_q;
   assign hresp  = hresp_q;

   logic unused_ok;
   assign unused_ok = ^{hburst, hprot, htrans[0]};

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Bench for ahb_sram_subordinate: three instances (0, 3 and 2 wait states) on one
// shared manager bus; only the instance chosen by sel_dut sees hsel.
`timescale 1ns/1ps
module tb_ahb_sram_subordinate;

   localparam int NDUT = 3;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel_b;
   logic [31:0] haddr_b;
   logic [1:0]  htrans_b;
   logic [2:0]  hsize_b;
   logic [2:0]  hburst_b;
   logic        hwrite_b;
   logic [31:0] hwdata_b;
   logic        blk;
   int          sel_dut;

   logic [NDUT-1:0] hsel_v, hrdy_in_v, hready_v, hresp_v;
   logic [31:0]     hrdata_v [NDUT];

   always #5 hclk = ~hclk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      assign hsel_v[g]    = hsel_b && (sel_dut == g);
      assign hrdy_in_v[g] = hready_v[g] && !blk;
      ahb_sram_subordinate #(
         .ADDR_WIDTH (32),
         .DATA_WIDTH (32),
         .MEM_DEPTH  (256),
         .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
      ) u_dut (
         .hclk     (hclk),
         .hresetn  (hresetn),
         .hsel     (hsel_v[g]),
         .haddr    (haddr_b),
         .htrans   (htrans_b),
         .hsize    (hsize_b),
         .hburst   (hburst_b),
         .hprot    (7'h03),
         .hwrite   (hwrite_b),
         .hwdata   (hwdata_b),
         .hready_in(hrdy_in_v[g]),
         .hrdata   (hrdata_v[g]),
         .hready   (hready_v[g]),
         .hresp    (hresp_v[g])
      );
   end

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
   endfunction

   // ---------------- vectors ----------------
   typedef struct {
      bit          sel;
      bit [1:0]    trans;
      bit          blk;
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          chk;      // use hand-written expectations below
      bit          exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   function automatic vec_t V(input bit sel, input bit [1:0] tr, input bit b, input bit wr,
                              input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                              input bit chk, input bit ee, input logic [31:0] er);
      vec_t v;
      v.sel = sel; v.trans = tr; v.blk = b; v.wr = wr; v.addr = a; v.size = sz;
      v.wdata = wd; v.chk = chk; v.exp_err = ee; v.exp_rd = er;
      return v;
   endfunction

   function automatic vec_t idle_v();
      return V(0, 2'd0, 0, 0, 32'h0, 3'd0, 32'h0, 0, 0, 32'h0);
   endfunction

   vec_t vq[$];

   // ---------------- reference model ----------------
   logic [7:0] mm [NDUT][1024];
   bit         mk [NDUT][1024];

   function automatic bit is_acc(input vec_t v);
      return v.sel && v.trans[1] && !v.blk;
   endfunction

   function automatic bit model_err(input vec_t v);
      int unsigned a;
      a = v.addr;
      return ((a >> 2) >= 256) || (v.size > 3'd2) || ((a % (32'd1 << v.size)) != 0);
   endfunction

   task automatic model_write(input int d, input vec_t v);
      int base, lane0;
      base  = int'(v.addr[9:2]) * 4;
      lane0 = int'(v.addr[1:0]);
      for (int b = 0; b < (1 << v.size); b++) begin
         mm[d][base + lane0 + b] = v.wdata[8*(lane0 + b) +: 8];
         mk[d][base + lane0 + b] = 1'b1;
      end
   endtask

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_fail = 0;

   task automatic cmp(input string nm, input logic [33:0] act, input logic [33:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got rdy/resp/data=%h required %h", nm, act, exp);
      end
   endtask

   // driver / data-phase state
   vec_t        ap, dp;
   int          dp_kind = 0;   // 0 no transfer, 1 OKAY, 2 ERROR
   int          dp_c = 0;
   logic [31:0] dp_rd, dp_mask;

   task automatic drive_ap(input vec_t v);
      hsel_b   = v.sel;
      htrans_b = v.trans;
      haddr_b  = v.addr;
      hsize_b  = v.size;
      hwrite_b = v.wr;
      blk      = v.blk;
      hburst_b = 3'b001;
   endtask

   task automatic promote(input vec_t v);
      bit err;
      dp = v; dp_c = 0; dp_rd = '0; dp_mask = '1;
      if (!is_acc(v)) begin
         dp_kind = 0;
      end else begin
         err = v.chk ? v.exp_err : model_err(v);
         dp_kind = err ? 2 : 1;
         if (v.chk) begin
            dp_rd = v.exp_rd;
         end else if (!err) begin
            for (int b = 0; b < 4; b++) begin
               dp_rd[8*b +: 8]   = mm[sel_dut][int'(v.addr[9:2]) * 4 + b];
               dp_mask[8*b +: 8] = mk[sel_dut][int'(v.addr[9:2]) * 4 + b] ? 8'hFF : 8'h00;
            end
         end
      end
   endtask

   // Returns 1 when the bus shows hready high (data phase ends at next edge).
   task automatic check_dp(output bit done);
      logic [33:0] act, exp;
      bit last;
      int d;
      d = sel_dut;
      act = {hready_v[d], hresp_v[d], hrdata_v[d]};
      case (dp_kind)
         1: begin
            last = (dp_c == ws_of(d));
            if (last && !dp.wr) begin
               act[31:0] = act[31:0] & dp_mask;
               exp = {1'b1, 1'b0, dp_rd & dp_mask};
            end else begin
               exp = {last, 1'b0, 32'h0};
            end
         end
         2: exp = {(dp_c != 0), 1'b1, 32'h0};
         default: exp = {1'b1, 1'b0, 32'h0};
      endcase
      cmp($sformatf("dut%0d kind%0d %s a=%h c=%0d", d, dp_kind, dp.wr ? "wr" : "rd", dp.addr, dp_c),
          act, exp);
      done = hready_v[d];
      if (dp_c >= 20) begin
         n_chk++; n_fail++;
         $display("FAIL timeout dut%0d: hready=%b after %0d cycles, required 1", d, hready_v[d], dp_c);
         done = 1'b1;
      end
   endtask

   // Pipelined manager: runs vq to completion. Entry/exit at posedge+1 with idle bus.
   task automatic run_q(output int real_cyc);
      bit done, fin;
      real_cyc = 0;
      fin = 0;
      ap = (vq.size() != 0) ? vq.pop_front() : idle_v();
      drive_ap(ap);
      while (!fin) begin
         @(negedge hclk);
         if (dp_kind != 0) real_cyc++;
         check_dp(done);
         if (done) begin
            if (dp_kind == 1 && dp.wr) model_write(sel_dut, dp);
            promote(ap);
            if (vq.size() == 0 && dp_kind == 0) fin = 1;
            else ap = (vq.size() != 0) ? vq.pop_front() : idle_v();
         end
         @(posedge hclk); #1;
         if (done) begin
            hwdata_b = dp.wdata;
            drive_ap(fin ? idle_v() : ap);
         end else begin
            dp_c++;
         end
      end
   endtask

   task automatic add_random(input int n);
      vec_t v;
      int w, off;
      for (int i = 0; i < n; i++) begin
         v = idle_v();
         v.sel   = ($urandom_range(0, 9) != 0);
         v.trans = 2'($urandom_range(0, 3));
         v.blk   = ($urandom_range(0, 15) == 0);
         v.wr    = 1'($urandom_range(0, 1));
         v.size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         w       = $urandom_range(0, 31);
         off     = $urandom_range(0, 3);
         if ($urandom_range(0, 7) != 0) off = off & ~((1 << v.size) - 1);
         v.addr  = ($urandom_range(0, 19) == 0) ? (32'h400 + 32'($urandom_range(0, 255)))
                                                : 32'(w * 4 + off);
         v.wdata = $urandom;
         vq.push_back(v);
      end
      vq.push_back(idle_v());
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int cyc;
      hresetn = 1'b0;
      sel_dut = 0;
      hwdata_b = '0;
      drive_ap(idle_v());
      #12;
      for (int d = 0; d < NDUT; d++)
         cmp($sformatf("reset dut%0d", d), {hready_v[d], hresp_v[d], hrdata_v[d]}, {1'b1, 1'b0, 32'h0});
      @(posedge hclk); #1;
      hresetn = 1'b1;

      // Write then back-to-back read, zero wait states.
      sel_dut = 0;
      vq.push_back(V(1, 2'd2, 0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 0, 32'h10, 3'd2, 32'h0,        1, 0, 32'hDEADBEEF));
      // Byte lanes, then halfword overwrite.
      vq.push_back(V(1, 2'd2, 0, 1, 32'h20, 3'd0, 32'h00000011, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 1, 32'h21, 3'd0, 32'h00002200, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 1, 32'h22, 3'd0, 32'h00330000, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 1, 32'h23, 3'd0, 32'h44000000, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 0, 32'h20, 3'd2, 32'h0,        1, 0, 32'h44332211));
      vq.push_back(V(1, 2'd2, 0, 1, 32'h22, 3'd1, 32'hAAAA0000, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 0, 32'h20, 3'd2, 32'h0,        1, 0, 32'hAAAA2211));
      // Error cases; erroneous write to 0x400 must not alias word 0.
      vq.push_back(V(1, 2'd2, 0, 1, 32'h00,  3'd2, 32'h0BADF00D, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 0, 32'h400, 3'd2, 32'h0,        1, 1, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 0, 32'h02,  3'd2, 32'h0,        1, 1, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 0, 32'h00,  3'd3, 32'h0,        1, 1, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 1, 32'h400, 3'd2, 32'hFFFFFFFF, 1, 1, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 0, 32'h00,  3'd2, 32'h0,        1, 0, 32'h0BADF00D));
      // INCR write burst with BUSY, IDLE with hsel, NONSEQ blocked by hready_in.
      vq.push_back(V(1, 2'd2, 0, 1, 32'h50, 3'd2, 32'h50500000, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd3, 0, 1, 32'h54, 3'd2, 32'h54541111, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd1, 0, 1, 32'h58, 3'd2, 32'hBAD0BAD0, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd3, 0, 1, 32'h58, 3'd2, 32'h58582222, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd3, 0, 1, 32'h5C, 3'd2, 32'h5C5C3333, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd0, 0, 1, 32'h60, 3'd2, 32'hBAD1BAD1, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 1, 1, 32'h50, 3'd2, 32'hDEAD0000, 1, 0, 32'h0));
      vq.push_back(idle_v());
      vq.push_back(V(1, 2'd2, 0, 0, 32'h50, 3'd2, 32'h0, 1, 0, 32'h50500000));
      vq.push_back(V(1, 2'd3, 0, 0, 32'h54, 3'd2, 32'h0, 1, 0, 32'h54541111));
      vq.push_back(V(1, 2'd1, 0, 0, 32'h58, 3'd2, 32'h0, 1, 0, 32'h0));
      vq.push_back(V(1, 2'd3, 0, 0, 32'h58, 3'd2, 32'h0, 1, 0, 32'h58582222));
      vq.push_back(V(1, 2'd3, 0, 0, 32'h5C, 3'd2, 32'h0, 1, 0, 32'h5C5C3333));
      vq.push_back(idle_v());
      run_q(cyc);

      // Three wait states: preload, then INCR4 read burst of 16 cycles.
      sel_dut = 1;
      for (int i = 0; i < 4; i++)
         vq.push_back(V(1, (i == 0) ? 2'd2 : 2'd3, 0, 1, 32'(32'h40 + 4*i), 3'd2,
                        32'(32'hA0A00000 + i), 1, 0, 32'h0));
      vq.push_back(V(1, 2'd2, 0, 0, 32'h402, 3'd2, 32'h0, 1, 1, 32'h0));
      vq.push_back(idle_v());
      run_q(cyc);
      for (int i = 0; i < 4; i++)
         vq.push_back(V(1, (i == 0) ? 2'd2 : 2'd3, 0, 0, 32'(32'h40 + 4*i), 3'd2, 32'h0,
                        1, 0, 32'(32'hA0A00000 + i)));
      vq.push_back(idle_v());
      run_q(cyc);
      cmp("burst_cycles", 34'(cyc), 34'd16);

      // Reset during the second wait cycle of a write (two wait states).
      sel_dut = 2;
      vq.push_back(V(1, 2'd2, 0, 1, 32'h30, 3'd2, 32'h12345678, 1, 0, 32'h0));
      vq.push_back(idle_v());
      run_q(cyc);
      drive_ap(V(1, 2'd2, 0, 1, 32'h30, 3'd2, 32'h0, 0, 0, 32'h0));
      @(posedge hclk); #1;
      drive_ap(idle_v());
      hwdata_b = 32'hCAFEF00D;
      @(posedge hclk); #1;
      cmp("wait2_before_reset", {hready_v[2], hresp_v[2], hrdata_v[2]}, {1'b0, 1'b0, 32'h0});
      #2 hresetn = 1'b0;
      #1;
      cmp("reset_async", {hready_v[2], hresp_v[2], hrdata_v[2]}, {1'b1, 1'b0, 32'h0});
      @(posedge hclk); @(posedge hclk); #1;
      hresetn = 1'b1;
      dp_kind = 0; dp_c = 0;
      vq.push_back(V(1, 2'd2, 0, 0, 32'h30, 3'd2, 32'h0, 1, 0, 32'h12345678));
      vq.push_back(idle_v());
      run_q(cyc);

      // Randomized traffic against the reference model on every instance.
      for (int d = 0; d < NDUT; d++) begin
         sel_dut = d;
         add_random((d == 0) ? 300 : 120);
         run_q(cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
